instruction_loader: RTL and testbench

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

---
 rtl/instruction_loader.sv | 131 +++++++++++++
 tb/tb_instruction_loader.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - streams host instruction words into instruction memory while holding the CPU pipeline
module instruction_loader #(
   parameter int          MEM_WORDS = 256,
   parameter int          CNT_W     = 9,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [CNT_W-1:0] i_word_count,
   input  logic             i_abort,
   input  logic [31:0]      i_data,
   input  logic             i_valid,
   output logic             o_ready,
   output logic             o_mem_write,
   output logic [31:0]      o_mem_addr,
   output logic [31:0]      o_mem_data,
   output logic             o_cpu_hold,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_error
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_FINISH
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] count, count_nxt;
   logic [CNT_W-1:0] index, index_nxt;
   logic             ready_nxt, write_nxt, hold_nxt, busy_nxt, done_nxt, error_nxt;
   logic [31:0]      addr_nxt, data_nxt;
   logic             handshake, is_last, count_ok;

   assign handshake = i_valid & o_ready;
   assign is_last   = (index == count - CNT_W'(1));
   assign count_ok  = (i_word_count != '0) && (i_word_count <= CNT_W'(MEM_WORDS));

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state       <= S_IDLE;
         count       <= '0;
         index       <= '0;
         o_ready     <= 1'b0;
         o_mem_write <= 1'b0;
         o_mem_addr  <= BASE_ADDR;
         o_mem_data  <= 32'h0;
         o_cpu_hold  <= 1'b0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_error     <= 1'b0;
      end else begin
         state       <= state_nxt;
         count       <= count_nxt;
         index       <= index_nxt;
         o_ready     <= ready_nxt;
         o_mem_write <= write_nxt;
         o_mem_addr  <= addr_nxt;
         o_mem_data  <= data_nxt;
         o_cpu_hold  <= hold_nxt;
         o_busy      <= busy_nxt;
         o_done      <= done_nxt;
         o_error     <= error_nxt;
      end
   end

   // Every output is registered: the values computed here appear one cycle later.
   always_comb begin
      state_nxt = state;
      count_nxt = count;
      index_nxt = index;
      ready_nxt = 1'b0;
      write_nxt = 1'b0;
      addr_nxt  = o_mem_addr;
      data_nxt  = o_mem_data;
      hold_nxt  = 1'b0;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;
      error_nxt = o_error;
      case (state)
         S_IDLE: begin
            if (i_start) begin
               if (count_ok) begin
                  count_nxt = i_word_count;
                  index_nxt = '0;
                  error_nxt = 1'b0;
                  ready_nxt = 1'b1;
                  hold_nxt  = 1'b1;
                  busy_nxt  = 1'b1;
                  state_nxt = S_LOAD;
               end else begin
                  error_nxt = 1'b1;
               end
            end
         end
         S_LOAD: begin
            ready_nxt = 1'b1;
            hold_nxt  = 1'b1;
            busy_nxt  = 1'b1;
            // Abort wins over a same-cycle handshake, so that word is dropped.
            if (i_abort) begin
               ready_nxt = 1'b0;
               hold_nxt  = 1'b0;
               busy_nxt  = 1'b0;
               error_nxt = 1'b1;
               state_nxt = S_IDLE;
            end else if (handshake) begin
               write_nxt = 1'b1;
               addr_nxt  = BASE_ADDR + 32'({index, 2'b00});
               data_nxt  = i_data;
               if (is_last) begin
                  ready_nxt = 1'b0;
                  done_nxt  = 1'b1;
                  state_nxt = S_FINISH;
               end else begin
                  index_nxt = index + CNT_W'(1);
               end
            end
         end
         S_FINISH: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_instruction_loader.sv
// tb/tb_instruction_loader.sv - scoreboard bench for instruction_loader
module tb_instruction_loader;

   localparam int          MEM_WORDS = 256;
   localparam int          CNT_W     = 9;
   localparam logic [31:0] BASE      = 32'h0000_0000;

   logic             i_clk;
   logic             i_reset;
   logic             i_start;
   logic [CNT_W-1:0] i_word_count;
   logic             i_abort;
   logic [31:0]      i_data;
   logic             i_valid;
   logic             o_ready;
   logic             o_mem_write;
   logic [31:0]      o_mem_addr;
   logic [31:0]      o_mem_data;
   logic             o_cpu_hold;
   logic             o_busy;
   logic             o_done;
   logic             o_error;

   instruction_loader #(
      .MEM_WORDS (MEM_WORDS),
      .CNT_W     (CNT_W),
      .BASE_ADDR (BASE)
   ) dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_start      (i_start),
      .i_word_count (i_word_count),
      .i_abort      (i_abort),
      .i_data       (i_data),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .o_mem_write  (o_mem_write),
      .o_mem_addr   (o_mem_addr),
      .o_mem_data   (o_mem_data),
      .o_cpu_hold   (o_cpu_hold),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_error      (o_error)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   logic [63:0] sb[$];
   logic [63:0] exp_wr;
   int          checks   = 0;
   int          errors   = 0;
   int          n_writes = 0;
   int          n_done   = 0;
   int          exp_idx  = 0;

   // Write monitor: every write must match the oldest expected {addr, data}.
   always @(posedge i_clk) begin
      #2;
      if (o_mem_write === 1'b1) begin
         n_writes++;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write addr=%h data=%h required=no_write", o_mem_addr, o_mem_data);
         end else begin
            exp_wr = sb.pop_front();
            if ({o_mem_addr, o_mem_data} !== exp_wr) begin
               errors++;
               $display("FAIL write_value got=%h_%h required=%h_%h", o_mem_addr, o_mem_data,
                        exp_wr[63:32], exp_wr[31:0]);
            end
         end
      end
      if (o_done === 1'b1) begin
         n_done++;
         checks++;
         if (o_mem_write !== 1'b1) begin
            errors++;
            $display("FAIL done_with_last_write mem_write=%b required=1", o_mem_write);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check_bit(input string name, input logic got, input logic req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s got=%b required=%b", name, got, req);
      end
   endtask

   task automatic check_int(input string name, input int got, input int req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s got=%0d required=%0d", name, got, req);
      end
   endtask

   task automatic start_load(input int cnt);
      i_start      = 1'b1;
      i_word_count = CNT_W'(cnt);
      exp_idx      = 0;
      @(negedge i_clk);
      i_start = 1'b0;
   endtask

   task automatic drive_word(input logic [31:0] d);
      int          k;
      logic [31:0] a;
      i_valid = 1'b1;
      i_data  = d;
      k       = 0;
      while (o_ready !== 1'b1 && k < 20) begin
         @(negedge i_clk);
         k++;
      end
      checks++;
      if (o_ready !== 1'b1) begin
         errors++;
         $display("FAIL handshake_timeout ready=%b required=1", o_ready);
      end else begin
         a = BASE + 32'(exp_idx) * 32'd4;
         sb.push_back({a, d});
         exp_idx++;
         @(negedge i_clk);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      checks++;
      if ({o_ready, o_mem_write, o_cpu_hold, o_busy, o_done, o_error} !== 6'b0 ||
          o_mem_addr !== BASE || o_mem_data !== 32'h0) begin
         errors++;
         $display("FAIL %s flags=%b addr=%h data=%h required=000000/%h/0", name,
                  {o_ready, o_mem_write, o_cpu_hold, o_busy, o_done, o_error}, o_mem_addr, o_mem_data, BASE);
      end
   endtask

   task automatic test_reset();
      i_reset = 1'b0; i_start = 1'b0; i_word_count = '0; i_abort = 1'b0;
      i_data = 32'h0; i_valid = 1'b0;
      repeat (3) @(negedge i_clk);
      check_reset_outputs("reset_state");
      i_reset = 1'b1;
      @(negedge i_clk);
      check_reset_outputs("idle_after_reset");
   endtask

   task automatic test_basic();
      int w0 = n_writes, d0 = n_done;
      start_load(3);
      check_bit("basic_busy", o_busy, 1'b1);
      check_bit("basic_hold", o_cpu_hold, 1'b1);
      check_bit("basic_ready", o_ready, 1'b1);
      drive_word(32'h2008_0005);
      drive_word(32'h2009_0007);
      drive_word(32'h0109_5020);
      i_valid = 1'b0;
      check_bit("finish_done", o_done, 1'b1);
      check_bit("finish_hold", o_cpu_hold, 1'b1);
      check_bit("finish_ready", o_ready, 1'b0);
      @(negedge i_clk);
      check_bit("post_done", o_done, 1'b0);
      check_bit("post_hold", o_cpu_hold, 1'b0);
      check_bit("post_busy", o_busy, 1'b0);
      check_int("basic_writes", n_writes - w0, 3);
      check_int("basic_done", n_done - d0, 1);
      check_int("basic_sb_empty", sb.size(), 0);
   endtask

   task automatic test_gap();
      int w0 = n_writes;
      start_load(2);
      drive_word(32'hCAFE_0001);
      i_valid      = 1'b0;
      i_start      = 1'b1;
      i_word_count = CNT_W'(1);
      for (int g = 0; g < 3; g++) begin
         check_bit("gap_ready", o_ready, 1'b1);
         @(negedge i_clk);
         i_start = 1'b0;
      end
      drive_word(32'hCAFE_0002);
      i_valid = 1'b0;
      @(negedge i_clk);
      check_int("gap_writes", n_writes - w0, 2);
      check_bit("gap_idle", o_busy, 1'b0);
   endtask

   task automatic test_no_ready();
      int w0 = n_writes;
      i_valid = 1'b1;
      i_data  = 32'hBAD0_BAD0;
      repeat (3) begin
         check_bit("idle_ready_low", o_ready, 1'b0);
         @(negedge i_clk);
      end
      i_valid = 1'b0;
      check_int("idle_valid_writes", n_writes - w0, 0);
   endtask

   task automatic test_bad_count();
      int w0 = n_writes;
      start_load(0);
      check_bit("cnt0_error", o_error, 1'b1);
      check_bit("cnt0_hold", o_cpu_hold, 1'b0);
      check_bit("cnt0_busy", o_busy, 1'b0);
      start_load(MEM_WORDS + 1);
      check_bit("cnt257_error", o_error, 1'b1);
      check_bit("cnt257_hold", o_cpu_hold, 1'b0);
      @(negedge i_clk);
      check_bit("cnt257_stay_idle", o_busy, 1'b0);
      check_int("bad_count_writes", n_writes - w0, 0);
      start_load(1);
      check_bit("good_clears_error", o_error, 1'b0);
      check_bit("good_busy", o_busy, 1'b1);
      drive_word(32'h1234_5678);
      i_valid = 1'b0;
      @(negedge i_clk);
      check_int("single_writes", n_writes - w0, 1);
   endtask

   task automatic test_abort();
      int w0 = n_writes, d0 = n_done;
      start_load(4);
      drive_word(32'hA000_0001);
      drive_word(32'hA000_0002);
      i_abort = 1'b1;
      i_valid = 1'b1;
      i_data  = 32'hDEAD_BEEF;
      @(negedge i_clk);
      i_abort = 1'b0;
      i_valid = 1'b0;
      check_bit("abort_error", o_error, 1'b1);
      check_bit("abort_busy", o_busy, 1'b0);
      check_bit("abort_hold", o_cpu_hold, 1'b0);
      check_bit("abort_ready", o_ready, 1'b0);
      check_bit("abort_write", o_mem_write, 1'b0);
      repeat (2) @(negedge i_clk);
      check_int("abort_writes", n_writes - w0, 2);
      check_int("abort_done", n_done - d0, 0);
      check_int("abort_sb_empty", sb.size(), 0);
   endtask

   task automatic test_full();
      int w0 = n_writes, d0 = n_done;
      start_load(MEM_WORDS);
      for (int i = 0; i < MEM_WORDS; i++) drive_word($urandom);
      i_valid = 1'b0;
      check_bit("full_done", o_done, 1'b1);
      checks++;
      if (o_mem_addr !== BASE + 32'h3FC) begin
         errors++;
         $display("FAIL full_last_addr got=%h required=%h", o_mem_addr, BASE + 32'h3FC);
      end
      repeat (4) @(negedge i_clk);
      check_int("full_writes", n_writes - w0, MEM_WORDS);
      check_int("full_done_count", n_done - d0, 1);
   endtask

   task automatic test_reset_mid();
      int w0 = n_writes, d0 = n_done;
      start_load(3);
      drive_word(32'hB000_0001);
      i_valid = 1'b1;
      i_data  = 32'hB000_0002;
      i_reset = 1'b0;
      #1;
      check_reset_outputs("async_reset_mid_load");
      @(negedge i_clk);
      i_reset = 1'b1;
      i_valid = 1'b0;
      sb.delete();
      @(negedge i_clk);
      check_int("reset_mid_writes", n_writes - w0, 1);
      check_int("reset_mid_done", n_done - d0, 0);
      check_bit("reset_mid_idle", o_busy, 1'b0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gap();
      test_no_ready();
      test_bad_count();
      test_abort();
      test_full();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
